// File: rtl/dag_path_counter.sv
// Path-count engine: counts DAG paths from one start node to NUM_TARGETS targets using a
// merging work queue. Define DAG_PATH_COUNTER_SAT_EN for saturating counts (count_saturated).
module dag_path_counter #(
   parameter int unsigned NODE_IDX_WIDTH = 10,
   parameter int unsigned ACCUM_WIDTH    = 48,
   parameter int unsigned QUEUE_DEPTH    = 64,
   parameter int unsigned NUM_TARGETS    = 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic                                  abort,
   input  logic [NODE_IDX_WIDTH-1:0]             start_node_idx,
   input  logic [NUM_TARGETS*NODE_IDX_WIDTH-1:0] target_idx,
   output logic                                  adj_req,
   output logic [NODE_IDX_WIDTH-1:0]             adj_node_idx,
   input  logic                                  adj_valid,
   input  logic [NODE_IDX_WIDTH-1:0]             adj_child_idx,
   input  logic                                  adj_last,
   input  logic                                  adj_none,
   output logic                                  busy,
   output logic                                  result_valid,
   output logic [NUM_TARGETS*ACCUM_WIDTH-1:0]    target_count,
   output logic                                  overflow
`ifdef DAG_PATH_COUNTER_SAT_EN
   ,
   output logic                                  count_saturated
`endif
);

   localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);

   typedef logic [ACCUM_WIDTH-1:0]    cnt_t;
   typedef logic [NODE_IDX_WIDTH-1:0] idx_t;
   typedef logic [PtrW-1:0]           ptr_t;

   typedef enum logic [2:0] {
      StIdle, StInit, StPop, StReq, StWaitEdge, StDone, StError
   } state_t;

   state_t                 state;
   idx_t                   q_idx [QUEUE_DEPTH];
   cnt_t                   q_cnt [QUEUE_DEPTH];
   logic [QUEUE_DEPTH-1:0] q_valid;
   ptr_t                   rd_ptr, wr_ptr;
   idx_t                   start_q;
   idx_t                   tgt_q [NUM_TARGETS];
   cnt_t                   tcnt  [NUM_TARGETS];
   idx_t                   cur_idx;
   cnt_t                   cur_cnt;

   function automatic cnt_t add_cnt(input cnt_t a, input cnt_t b);
`ifdef DAG_PATH_COUNTER_SAT_EN
      logic [ACCUM_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[ACCUM_WIDTH] ? '1 : s[ACCUM_WIDTH-1:0];
`else
      return a + b;
`endif
   endfunction

   logic                   beat, child_beat, full, empty, any_tgt, q_hit_any;
   logic                   push_new, q_ovf;
   logic [NUM_TARGETS-1:0] tgt_hit;
   ptr_t                   hit_ptr;
   cnt_t                   q_sum;
   cnt_t                   tsum [NUM_TARGETS];
   logic                   q_we;
   ptr_t                   q_waddr;
   idx_t                   q_widx;
   cnt_t                   q_wcnt;

   // Empty and full share rd_ptr == wr_ptr; the valid bit at wr_ptr tells them apart.
   assign full       = q_valid[wr_ptr];
   assign empty      = (rd_ptr == wr_ptr) && !full;
   assign beat       = (state == StWaitEdge) && adj_valid && !abort;
   assign child_beat = beat && !adj_none;
   assign push_new   = child_beat && !any_tgt && !q_hit_any;
   assign q_ovf      = push_new && full;
   assign busy       = (state != StIdle);

   always_comb begin
      tgt_hit = '0;
      for (int k = 0; k < NUM_TARGETS; k++) begin
         tgt_hit[k] = (adj_child_idx == tgt_q[k]);
         tsum[k]    = add_cnt(tcnt[k], cur_cnt);
      end
      any_tgt = |tgt_hit;

      // Ascending scan so the highest matching index wins.
      q_hit_any = 1'b0;
      hit_ptr   = '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         if (q_valid[i] && (q_idx[i] == adj_child_idx)) begin
            q_hit_any = 1'b1;
            hit_ptr   = ptr_t'(i);
         end
      end
      q_sum = add_cnt(q_cnt[hit_ptr], cur_cnt);

      q_we    = 1'b0;
      q_waddr = wr_ptr;
      q_widx  = adj_child_idx;
      q_wcnt  = cur_cnt;
      if (!abort && (state == StInit)) begin
         q_we   = 1'b1;
         q_widx = start_q;
         q_wcnt = cnt_t'(1);
      end else if (child_beat && !any_tgt) begin
         if (q_hit_any) begin
            q_we    = 1'b1;
            q_waddr = hit_ptr;
            q_wcnt  = q_sum;
         end else if (!full) begin
            q_we = 1'b1;
         end
      end
   end

`ifdef DAG_PATH_COUNTER_SAT_EN
   logic sat_q, sat_ev;

   function automatic logic add_ovf(input cnt_t a, input cnt_t b);
      cnt_t s;
      s = a + b;
      return s < a;
   endfunction

   always_comb begin
      sat_ev = 1'b0;
      if (child_beat) begin
         if (any_tgt) begin
            for (int k = 0; k < NUM_TARGETS; k++) begin
               if (tgt_hit[k] && add_ovf(tcnt[k], cur_cnt)) sat_ev = 1'b1;
            end
         end else if (q_hit_any) begin
            sat_ev = add_ovf(q_cnt[hit_ptr], cur_cnt);
         end
      end
   end

   assign count_saturated = sat_q;
`endif

   always_ff @(posedge clk) begin
      if (q_we) begin
         q_idx[q_waddr] <= q_widx;
         q_cnt[q_waddr] <= q_wcnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= StIdle;
         q_valid      <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         start_q      <= '0;
         cur_idx      <= '0;
         cur_cnt      <= '0;
         adj_req      <= 1'b0;
         adj_node_idx <= '0;
         result_valid <= 1'b0;
         overflow     <= 1'b0;
         for (int k = 0; k < NUM_TARGETS; k++) begin
            tgt_q[k] <= '0;
            tcnt[k]  <= '0;
         end
`ifdef DAG_PATH_COUNTER_SAT_EN
         sat_q <= 1'b0;
`endif
      end else if (abort) begin
         state   <= StIdle;
         q_valid <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         adj_req <= 1'b0;
      end else begin
         adj_req <= 1'b0;
`ifdef DAG_PATH_COUNTER_SAT_EN
         if (sat_ev) sat_q <= 1'b1;
`endif
         unique case (state)
            StIdle: begin
               if (start) begin
                  result_valid <= 1'b0;
                  overflow     <= 1'b0;
                  q_valid      <= '0;
                  rd_ptr       <= '0;
                  wr_ptr       <= '0;
                  start_q      <= start_node_idx;
                  for (int k = 0; k < NUM_TARGETS; k++) begin
                     tgt_q[k] <= target_idx[k*NODE_IDX_WIDTH +: NODE_IDX_WIDTH];
                     tcnt[k]  <= '0;
                  end
`ifdef DAG_PATH_COUNTER_SAT_EN
                  sat_q <= 1'b0;
`endif
                  state <= StInit;
               end
            end
            StInit: begin
               q_valid[wr_ptr] <= 1'b1;
               wr_ptr          <= wr_ptr + ptr_t'(1);
               state           <= StPop;
            end
            StPop: begin
               if (empty) begin
                  result_valid <= 1'b1;
                  state        <= StDone;
               end else begin
                  cur_idx         <= q_idx[rd_ptr];
                  cur_cnt         <= q_cnt[rd_ptr];
                  q_valid[rd_ptr] <= 1'b0;
                  rd_ptr          <= rd_ptr + ptr_t'(1);
                  state           <= StReq;
               end
            end
            StReq: begin
               adj_req      <= 1'b1;
               adj_node_idx <= cur_idx;
               state        <= StWaitEdge;
            end
            StWaitEdge: begin
               if (adj_valid) begin
                  if (child_beat && any_tgt) begin
                     for (int k = 0; k < NUM_TARGETS; k++) begin
                        if (tgt_hit[k]) tcnt[k] <= tsum[k];
                     end
                  end
                  if (q_ovf) begin
                     overflow <= 1'b1;
                     state    <= StError;
                  end else begin
                     if (push_new) begin
                        q_valid[wr_ptr] <= 1'b1;
                        wr_ptr          <= wr_ptr + ptr_t'(1);
                     end
                     if (adj_none || adj_last) state <= StPop;
                  end
               end
            end
            StDone:  state <= StIdle;
            StError: state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_TARGETS; k++) begin : g_pack
      assign target_count[k*ACCUM_WIDTH +: ACCUM_WIDTH] = tcnt[k];
   end

endmodule
